uart_rx_fifo: RTL
=================

# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of `uart_rx`. It captures each received byte on the `rx_done` pulse and holds it until the consumer (loopback TX path or counter/command logic) pops it. It decouples the UART bit timing from the consumer and flags lost bytes. Show-ahead (first-word fall-through) read interface; single clock domain.

## Interface
- `DEPTH`, 16: number of byte entries; power of two, ≥2.
- `AF_LEVEL`, 12: almost-full threshold in entries, 1..DEPTH-1 (used only with `UART_RX_FIFO_AF_EN`).
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `push`  in  1  write strobe; connect to `uart_rx.rx_done`, 1-cycle pulse.
- `wdata`  in  8  byte to store; connect to `uart_rx.rx_data`.
- `pop`  in  1  consumer read-acknowledge; removes head entry.
- `rdata`  out  8  head entry; valid whenever `empty`=0.
- `empty`  out  1  no entries stored.
- `full`  out  1  DEPTH entries stored.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  sticky: a push was dropped.
- `clr_ovf`  in  1  clears `overflow`.
- `almost_full`  out  1  occupancy ≥ AF_LEVEL (see Configuration).

## Operation
- Storage: DEPTH×8 register array; write pointer `wp`, read pointer `rp`, each $clog2(DEPTH) bits, wrap modulo DEPTH naturally; occupancy register `count` tracked separately.
- Accepted push (`push`=1 and (`full`=0 or `pop`=1)): mem[wp] ← wdata, wp ← wp+1.
- Accepted pop (`pop`=1 and `empty`=0): rp ← rp+1.
- `count` next: +1 on accepted push only, −1 on accepted pop only, unchanged when both or neither.
- Full and push and pop same cycle: both accepted; count stays DEPTH; no overflow.
- Empty and push and pop same cycle: push accepted, pop ignored; count → 1.
- Push while full without pop: byte discarded, memory and pointers unchanged, `overflow` ← 1.
- Pop while empty: ignored; no state change; no error flag.
- `overflow`: set has priority over `clr_ovf` in the same cycle; otherwise `clr_ovf`=1 clears it.
- `rdata` = mem[rp] combinationally (show-ahead); content while `empty`=1 is don't-care, but must not be X after reset (array reset to 0).
- `empty` = (count==0), `full` = (count==DEPTH), derived from registered `count`.

## Timing
- Reset (rst=0, asynchronous): wp=rp=0, count=0, all entries 0, overflow=0 → `empty`=1, `full`=0, `count`=0, `rdata`=0x00, `overflow`=0, `almost_full`=0.
- Reset release mid-traffic: contents lost; first push after release lands at entry 0.
- Push-to-visible latency: byte pushed at edge N appears on `rdata` with `empty`=0 after edge N (same cycle as count update), i.e. 1 cycle.
- Pop: `rdata` advances to next entry after the popping edge; consumer samples `rdata` in the cycle it asserts `pop`.
- `push` held high multiple cycles writes once per cycle; upstream guarantees 1-cycle `rx_done`.
- No combinational path from `pop`/`push` to any output.

## Configuration
- `UART_RX_FIFO_AF_EN` defined: `almost_full` = registered-count comparison (count ≥ AF_LEVEL), updated with `count`; used for flow control.
- Not defined: comparison logic not built; `almost_full` tied 0; `AF_LEVEL` ignored. All other behaviour identical.

## Test plan
- Reset: assert rst=0 mid-run with 5 entries stored → empty=1, count=0, rdata=0x00, overflow=0 immediately, without clock edge.
- Ordering: push 0x41,0x42,0x43 then pop ×3 → rdata sequence 0x41,0x42,0x43, empty=1 after third pop, count 3→0.
- Fill/overflow (DEPTH=16): push 0x00..0x10 (17 bytes) → full=1 at 16, overflow=1, 0x10 dropped; drain yields 0x00..0x0F; clr_ovf → overflow=0.
- Simultaneous: at full, push 0xAA with pop → count stays 16, overflow=0, 0xAA read last; at empty, push 0x55 with pop → count=1, rdata=0x55.
- Wrap: 40 push/pop pairs with depth ≤3 → pointers wrap twice, every byte returned in order, overflow=0; pop on empty → no change.
- Macro on, AF_LEVEL=12: push 11 → almost_full=0; 12th → 1; one pop → 0. Macro off → almost_full=0 throughout.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive byte FIFO with sticky overflow flag
// Optional almost_full comparison is built only when UART_RX_FIFO_AF_EN is defined.
module uart_rx_fifo #(
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf,
  output logic                     almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH - 1) begin : g_bad_af
    $error("uart_rx_fifo: AF_LEVEL must be in 1..DEPTH-1");
  end

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] cnt;
  logic          ovf;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push_ok = push && (!full || pop);
  assign pop_ok  = pop && !empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wp] <= wdata;
        wp      <= wp + 1'b1;
      end
      if (pop_ok) rp <= rp + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
      if (push && !push_ok) ovf <= 1'b1;
      else if (clr_ovf)     ovf <= 1'b0;
    end
  end

  assign rdata    = mem[rp];
  assign count    = cnt;
  assign overflow = ovf;

`ifdef UART_RX_FIFO_AF_EN
  assign almost_full = (cnt >= CW'(AF_LEVEL));
`else
  assign almost_full = 1'b0;
`endif

endmodule
